// File: rtl/register_file_sb.sv
`timescale 1ns / 1ps
// ----------------------------------------------------------------------------
// register_file_sb
//
// Register file for the MIPS multicycle datapath with two read ports, one
// write port, write-to-read bypass and a per-register busy scoreboard.
// Decode presents the read addresses; writeback drives the write port.
// Multicycle control marks a destination register pending when its producer
// issues (busy_set_*), and the writeback to that register releases it.
//
// Parameters
//   WIDTH    data word width in bits
//   SIZE     register address width, DEPTH = 2**SIZE registers (SIZE >= 1)
//   REG_READ 0 = combinational read, 1 = registered read (1-cycle latency)
//   ZERO_REG 1 = register 0 is hardwired zero, ignores writes, never busy
//
// Ports
//   clk                 rising-edge clock
//   reset               asynchronous active-low reset
//   reg_write_i         write enable
//   write_register_i    write address
//   write_data_i        write data
//   read_register_1_i   read port 1 address
//   read_register_2_i   read port 2 address
//   read_data_1_o       read port 1 data
//   read_data_2_o       read port 2 data
//   busy_set_i          mark busy_set_reg_i as pending
//   busy_set_reg_i      register to mark pending
//   busy_1_o            register on read port 1 is pending (bypass-masked)
//   busy_2_o            register on read port 2 is pending (bypass-masked)
//   busy_vector_o       stored busy bits, one per register, no masking
// ----------------------------------------------------------------------------
module register_file_sb #(
  parameter int WIDTH    = 32,
  parameter int SIZE     = 5,
  parameter int REG_READ = 0,
  parameter int ZERO_REG = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 reg_write_i,
  input  logic [SIZE-1:0]      write_register_i,
  input  logic [WIDTH-1:0]     write_data_i,
  input  logic [SIZE-1:0]      read_register_1_i,
  input  logic [SIZE-1:0]      read_register_2_i,
  output logic [WIDTH-1:0]     read_data_1_o,
  output logic [WIDTH-1:0]     read_data_2_o,
  input  logic                 busy_set_i,
  input  logic [SIZE-1:0]      busy_set_reg_i,
  output logic                 busy_1_o,
  output logic                 busy_2_o,
  output logic [2**SIZE-1:0]   busy_vector_o
);

  localparam int DEPTH = 2**SIZE;

  // Current contents of every register and its busy bit, gathered from the
  // per-register slices below.
  logic [WIDTH-1:0] reg_arr [DEPTH];
  logic [DEPTH-1:0] busy_vec;

  logic             we_eff;
  logic             hit_1;
  logic             hit_2;
  logic [WIDTH-1:0] rd_1_val;
  logic [WIDTH-1:0] rd_2_val;

  // A write to register 0 is dropped entirely when it is hardwired to zero,
  // so it neither updates storage, bypasses, nor clears a busy bit.
  always_comb begin
    we_eff = reg_write_i;
    if ((ZERO_REG != 0) && (write_register_i == '0)) begin
      we_eff = 1'b0;
    end
  end

  // --------------------------------------------------------------------------
  // Per-register storage and scoreboard bit
  // --------------------------------------------------------------------------
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_reg
    if ((ZERO_REG != 0) && (gi == 0)) begin : g_zero
      assign reg_arr[gi]  = '0;
      assign busy_vec[gi] = 1'b0;
    end else begin : g_norm
      logic             wr_sel;
      logic             set_sel;
      logic [WIDTH-1:0] data_q;
      logic [WIDTH-1:0] data_d;
      logic             busy_q;
      logic             busy_d;

      always_comb begin
        wr_sel  = we_eff && (write_register_i == SIZE'(gi));
        set_sel = busy_set_i && (busy_set_reg_i == SIZE'(gi));
      end

      always_comb begin
        data_d = data_q;
        if (wr_sel) begin
          data_d = write_data_i;
        end
        // Writeback releases the register; a producer issuing in the same
        // cycle is newer than that writeback, so the set is applied last.
        busy_d = busy_q;
        if (wr_sel) begin
          busy_d = 1'b0;
        end
        if (set_sel) begin
          busy_d = 1'b1;
        end
      end

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          data_q <= '0;
          busy_q <= 1'b0;
        end else begin
          data_q <= data_d;
          busy_q <= busy_d;
        end
      end

      assign reg_arr[gi]  = data_q;
      assign busy_vec[gi] = busy_q;
    end
  end

  // --------------------------------------------------------------------------
  // Read selection with write-to-read bypass
  // --------------------------------------------------------------------------
  always_comb begin
    hit_1 = we_eff && (read_register_1_i == write_register_i);
    hit_2 = we_eff && (read_register_2_i == write_register_i);

    rd_1_val = hit_1 ? write_data_i : reg_arr[read_register_1_i];
    rd_2_val = hit_2 ? write_data_i : reg_arr[read_register_2_i];

    if ((ZERO_REG != 0) && (read_register_1_i == '0)) begin
      rd_1_val = '0;
    end
    if ((ZERO_REG != 0) && (read_register_2_i == '0)) begin
      rd_2_val = '0;
    end
  end

  // A register written this cycle is reported free: its value is already
  // available through the bypass.
  always_comb begin
    busy_1_o = busy_vec[read_register_1_i] && !hit_1;
    busy_2_o = busy_vec[read_register_2_i] && !hit_2;
  end

  assign busy_vector_o = busy_vec;

  // --------------------------------------------------------------------------
  // Output stage
  // --------------------------------------------------------------------------
  if (REG_READ != 0) begin : g_reg_read
    logic [WIDTH-1:0] rdata_1_q;
    logic [WIDTH-1:0] rdata_1_d;
    logic [WIDTH-1:0] rdata_2_q;
    logic [WIDTH-1:0] rdata_2_d;

    // The captured value includes this cycle's write, so a read issued
    // alongside a write to the same register returns the new data.
    always_comb begin
      rdata_1_d = rd_1_val;
      rdata_2_d = rd_2_val;
    end

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        rdata_1_q <= '0;
        rdata_2_q <= '0;
      end else begin
        rdata_1_q <= rdata_1_d;
        rdata_2_q <= rdata_2_d;
      end
    end

    assign read_data_1_o = rdata_1_q;
    assign read_data_2_o = rdata_2_q;
  end else begin : g_comb_read
    // Storage is already zero under reset; forcing the outputs as well keeps
    // a write presented during reset from leaking through the bypass.
    assign read_data_1_o = reset ? rd_1_val : '0;
    assign read_data_2_o = reset ? rd_2_val : '0;
  end

endmodule

// File: doc/register_file_sb.md
Name: register_file_sb

Overview:
Parametrised successor register file for the MIPS multicycle datapath.
- Storage: 2**SIZE words of WIDTH bits, two read ports, one write port.
- Write-to-read bypass; selectable combinational or registered read.
- Per-register busy scoreboard: multicycle control marks a destination register pending when a producer issues, and the scoreboard releases it on writeback.
- Sits between decode (read addresses) and writeback (write port) in the data path.

Parameters:
- WIDTH, 32, data word width in bits.
- SIZE, 5, register address width; DEPTH = 2**SIZE registers.
- REG_READ, 0, read mode. 0 = combinational read (0-cycle latency). 1 = registered read (1-cycle latency).
- ZERO_REG, 1, read mode for register 0. 1 = register 0 reads as zero, ignores writes and is never busy. 0 = register 0 is an ordinary register.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- reg_write_i  input  1  write enable.
- write_register_i  input  SIZE  write address.
- write_data_i  input  WIDTH  write data.
- read_register_1_i  input  SIZE  read port 1 address.
- read_register_2_i  input  SIZE  read port 2 address.
- read_data_1_o  output  WIDTH  read port 1 data.
- read_data_2_o  output  WIDTH  read port 2 data.
- busy_set_i  input  1  mark a register pending.
- busy_set_reg_i  input  SIZE  register to mark pending.
- busy_1_o  output  1  read port 1 register is pending.
- busy_2_o  output  1  read port 2 register is pending.
- busy_vector_o  output  2**SIZE  stored busy bits, one per register.

Behaviour:

Reset (reset low, asynchronous):
- All registers clear to 0.
- All busy bits clear to 0.
- In REG_READ=1, read_data_x_o registers clear to 0.
- Reset has priority over every other input, including mid-operation; no write or busy-set taken on the release edge takes effect while reset is low.

Effective write:
- we_eff = reg_write_i AND NOT (ZERO_REG AND write_register_i==0).
- On the edge with we_eff, reg[write_register_i] <= write_data_i.

Bypass:
- hit_x = we_eff AND (read_register_x_i == write_register_i).

REG_READ=0:
- read_data_x_o = hit_x ? write_data_i : reg[read_register_x_i], combinational, same cycle.
- Register 0 reads 0 when ZERO_REG=1.

REG_READ=1:
- At each edge, read_data_x_o <= (hit_x ? write_data_i : reg[read_register_x_i]).
- The sampled value is therefore post-write data; latency is exactly 1 cycle.

Scoreboard, busy[i] update at the edge:
- Cleared when we_eff and write_register_i == i.
- Set when busy_set_i and busy_set_reg_i == i.
- Set and clear on the same register in the same cycle: set wins (new producer issued after the old writeback).
- Set on an already busy register: stays 1, no counting.
- Clear on a non-busy register: stays 0.
- ZERO_REG=1: busy[0] is held at 0; busy_set to register 0 is ignored.

Busy outputs:
- busy_x_o = busy[read_register_x_i] AND NOT hit_x.
- This is combinational in both REG_READ modes; a register being written this cycle reports not busy because its data is bypassed.
- busy_vector_o = stored busy bits, without bypass masking.

Read ports:
- Both ports are independent; the same address on both ports returns identical data.

Width rules:
- No arithmetic; addresses are used unsigned.
- SIZE must be at least 1.

Test Plan:
1. Reset low mid-stream after registers 5 and 9 were written and 5 marked busy. Required: all read_data=0, busy_vector_o=0 immediately (asynchronous), before any clock edge.
2. REG_READ=0: write 0xDEADBEEF to r7 with read_register_1_i=7 in the same cycle. Required: read_data_1_o=0xDEADBEEF that cycle. Next cycle with reg_write_i=0: still 0xDEADBEEF.
3. ZERO_REG=1: write 0x12345678 to r0 and busy_set r0. Required: reading r0 returns 0; busy_vector_o[0]=0; busy_1_o=0.
4. Scoreboard sequence:
   - busy_set r3; next cycle required: busy_vector_o[3]=1, busy_1_o=1 when reading r3.
   - Write r3 with 0xA5A5A5A5 the following cycle. Required: busy_1_o=0 that cycle (bypass). After the edge: busy_vector_o[3]=0, data=0xA5A5A5A5.
5. Simultaneous busy_set r4 and write r4 (r4 already busy). Required: after the edge, busy_vector_o[4]=1 and r4 holds the written data.
6. REG_READ=1: write r10=0x0000_00FF while reading r10 on both ports. Required:
   - Outputs unchanged during the write cycle.
   - 0x000000FF on both ports one cycle later.
   - Consecutive reads of r1, r2 return their values with exactly 1-cycle lag.
